demux8x8_reg: RTL and testbench

//   Write-side counterpart of the 8:1 byte read mux: steers one 8-bit bus byte into one of

---
 rtl/demux8x8_reg_pkg.sv | 15 +
 rtl/demux8x8_reg_if.sv | 16 +
 rtl/demux8x8_reg_dec3to8.sv | 15 +
 rtl/demux8x8_reg.sv | 131 +++++++++++++
 tb/tb_demux8x8_reg.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux8x8_reg_pkg.sv
// Shared constants and FSM state type for the demux8x8_reg write-side byte demux.
// Optional dirty-flag logic in the top is enabled by DEMUX8X8_DIRTY_EN.
package demux8x8_reg_pkg;

  localparam int SEL_W    = 3;
  localparam int NUM_DEST = 8;

  // The state is the occupancy of the stage/skid pair
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/demux8x8_reg_if.sv
// Write-request handshake bus: requester drives valid/sel/data, the demux returns ready.
// Used by demux8x8_reg (DEMUX8X8_DIRTY_EN does not change this bus).
interface demux8x8_reg_if #(
  parameter int WIDTH = 8
);
  import demux8x8_reg_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_sel, output in_data, input in_ready);
  modport slave  (input in_valid, input in_sel, input in_data, output in_ready);

endinterface

// File: rtl/demux8x8_reg_dec3to8.sv
// One-hot 3-to-8 decoder gated by an enable; produces destination write strobes.
// Unaffected by DEMUX8X8_DIRTY_EN.
module dec3to8
  import demux8x8_reg_pkg::*;
(
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  output logic [NUM_DEST-1:0] strobe
);

  for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_dec
    assign strobe[gi] = en && (sel == SEL_W'(gi));
  end

endmodule

// File: rtl/demux8x8_reg.sv
// Steers bus bytes into eight destination registers through an in-order stage+skid buffer.
// Define DEMUX8X8_DIRTY_EN to add per-destination dirty flags (dirty/dirty_clr ports).
module demux8x8_reg
  import demux8x8_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                reset,
  demux8x8_reg_if.slave       bus,
  input  logic                hold,
  output logic                busy,
  output logic [WIDTH-1:0]    out0,
  output logic [WIDTH-1:0]    out1,
  output logic [WIDTH-1:0]    out2,
  output logic [WIDTH-1:0]    out3,
  output logic [WIDTH-1:0]    out4,
  output logic [WIDTH-1:0]    out5,
  output logic [WIDTH-1:0]    out6,
  output logic [WIDTH-1:0]    out7
`ifdef DEMUX8X8_DIRTY_EN
  ,
  output logic [NUM_DEST-1:0] dirty,
  input  logic                dirty_clr
`endif
);

  state_t                           state_reg;
  logic [SEL_W-1:0]                 stage_sel_reg;
  logic [WIDTH-1:0]                 stage_data_reg;
  logic [SEL_W-1:0]                 skid_sel_reg;
  logic [WIDTH-1:0]                 skid_data_reg;
  logic                             accept;
  logic                             commit;
  logic [NUM_DEST-1:0]              wr_strobe;
  logic [NUM_DEST-1:0][WIDTH-1:0]   dest_vec;

  // Gated by reset so no request is taken while pending writes are being discarded
  assign bus.in_ready = (state_reg != ST_FULL) && !reset;
  assign accept       = bus.in_valid && bus.in_ready;
  assign commit       = (state_reg != ST_EMPTY) && !hold;
  assign busy         = (state_reg != ST_EMPTY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_EMPTY;
      stage_sel_reg  <= '0;
      stage_data_reg <= '0;
      skid_sel_reg   <= '0;
      skid_data_reg  <= '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            stage_sel_reg  <= bus.in_sel;
            stage_data_reg <= bus.in_data;
            state_reg      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (!hold) begin
            if (accept) begin
              stage_sel_reg  <= bus.in_sel;
              stage_data_reg <= bus.in_data;
            end else begin
              state_reg <= ST_EMPTY;
            end
          end else if (accept) begin
            skid_sel_reg  <= bus.in_sel;
            skid_data_reg <= bus.in_data;
            state_reg     <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (!hold) begin
            stage_sel_reg  <= skid_sel_reg;
            stage_data_reg <= skid_data_reg;
            state_reg      <= ST_ONE;
          end
        end
        default: state_reg <= ST_EMPTY;
      endcase
    end
  end

  dec3to8 u_dec (
    .en     (commit),
    .sel    (stage_sel_reg),
    .strobe (wr_strobe)
  );

  for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_dest
    logic [WIDTH-1:0] dest_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        dest_reg <= RESET_VAL;
      end else if (wr_strobe[gi]) begin
        dest_reg <= stage_data_reg;
      end
    end

    assign dest_vec[gi] = dest_reg;
  end

  assign out0 = dest_vec[0];
  assign out1 = dest_vec[1];
  assign out2 = dest_vec[2];
  assign out3 = dest_vec[3];
  assign out4 = dest_vec[4];
  assign out5 = dest_vec[5];
  assign out6 = dest_vec[6];
  assign out7 = dest_vec[7];

`ifdef DEMUX8X8_DIRTY_EN
  logic [NUM_DEST-1:0] dirty_reg;

  // A commit on the clearing edge survives the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty_reg <= '0;
    end else begin
      dirty_reg <= (dirty_clr ? '0 : dirty_reg) | wr_strobe;
    end
  end

  assign dirty = dirty_reg;
`endif

endmodule

// File: tb/tb_demux8x8_reg.sv
// Self-checking bench for demux8x8_reg; exercises DEMUX8X8_DIRTY_EN paths when defined.
module tb_demux8x8_reg;
  import demux8x8_reg_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       hold;
  logic       busy;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
  wire  [7:0] outs [8];
`ifdef DEMUX8X8_DIRTY_EN
  logic [7:0] dirty;
  logic       dirty_clr;
`endif

  int nchecks = 0;
  int nerrors = 0;

  demux8x8_reg_if #(.WIDTH(8)) ifc ();

  demux8x8_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc),
    .hold  (hold),
    .busy  (busy),
    .out0  (out0),
    .out1  (out1),
    .out2  (out2),
    .out3  (out3),
    .out4  (out4),
    .out5  (out5),
    .out6  (out6),
    .out7  (out7)
`ifdef DEMUX8X8_DIRTY_EN
    ,
    .dirty     (dirty),
    .dirty_clr (dirty_clr)
`endif
  );

  always #5 clk = ~clk;

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;
  assign outs[6] = out6;
  assign outs[7] = out7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      $display("check %s: %0h ok", name, act);
    end
  endtask

  // Scoreboard: accepted writes queued in order, popped when a destination changes
  logic [10:0] exp_q [$];
  logic        rst_at_edge = 1'b1;
  logic [7:0]  snap [8];

  always @(posedge clk) begin
    rst_at_edge <= reset;
    if (reset) begin
      exp_q.delete();
    end else if (ifc.in_valid && ifc.in_ready) begin
      exp_q.push_back({ifc.in_sel, ifc.in_data});
      $display("accept sel=%0d data=%02h", ifc.in_sel, ifc.in_data);
    end
  end

  always @(negedge clk) begin
    if (!rst_at_edge) begin
      for (int i = 0; i < 8; i++) begin
        if (outs[i] !== snap[i]) begin
          if (exp_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL commit_unexpected: out%0d changed to %02h, expected no commit", i, outs[i]);
          end else begin
            logic [10:0] e;
            e = exp_q.pop_front();
            chk("commit_sel", i, 32'(e[10:8]));
            chk("commit_data", 32'(outs[i]), 32'(e[7:0]));
          end
        end
      end
    end
    for (int i = 0; i < 8; i++) snap[i] = outs[i];
  end

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       exp_ready;
  } wr_vec_t;

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } out_vec_t;

  wr_vec_t  wr_tbl [8];
  out_vec_t out_tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d);
    ifc.in_valid = v;
    ifc.in_sel   = s;
    ifc.in_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 8; k++) begin
      wr_tbl[k]  = '{sel: 3'(k), data: 8'h10 + 8'(k), exp_ready: 1'b1};
      out_tbl[k] = '{idx: k, exp: 8'h10 + 8'(k)};
    end
    out_tbl[2].exp = 8'h12;

    reset = 1'b1;
    hold  = 1'b0;
    drive(1'b0, 3'd0, 8'h00);
`ifdef DEMUX8X8_DIRTY_EN
    dirty_clr = 1'b0;
`endif
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) chk("rst_out", 32'(outs[i]), 32'h00);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(ifc.in_ready), 32'd1);

    // 1: single write, two-edge visibility
    step();
    drive(1'b1, 3'd5, 8'hA5);
    step();
    drive(1'b0, 3'd0, 8'h00);
    @(negedge clk);
    chk("t1_busy_after_accept", 32'(busy), 32'd1);
    chk("t1_out5_before_commit", 32'(out5), 32'h00);
    step();
    @(negedge clk);
    chk("t1_out5", 32'(out5), 32'hA5);
    chk("t1_busy_after_commit", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) if (i != 5) chk("t1_other_out", 32'(outs[i]), 32'h00);

    // 2: back-to-back writes from table
    step();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, wr_tbl[k].sel, wr_tbl[k].data);
      @(negedge clk);
      chk("t2_in_ready", 32'(ifc.in_ready), 32'(wr_tbl[k].exp_ready));
      step();
    end
    drive(1'b0, 3'd0, 8'h00);
    step();
    @(negedge clk);
    chk("t2_busy_idle", 32'(busy), 32'd0);
    for (int k = 0; k < 8; k++) chk("t2_out", 32'(outs[out_tbl[k].idx]), 32'(8'h10 + 8'(k)));

    // 3: hold fills stage+skid, third request stalls, drains in order
    step();
    hold = 1'b1;
    drive(1'b1, 3'd2, 8'h11);
    step();
    drive(1'b1, 3'd2, 8'h22);
    step();
    drive(1'b1, 3'd4, 8'h33);
    @(negedge clk);
    chk("t3_full_ready", 32'(ifc.in_ready), 32'd0);
    chk("t3_full_busy", 32'(busy), 32'd1);
    step();
    step();
    @(negedge clk);
    chk("t3_hold_out2", 32'(out2), 32'h12);
    chk("t3_hold_ready", 32'(ifc.in_ready), 32'd0);
    hold = 1'b0;
    step();
    @(negedge clk);
    chk("t3_out2_first", 32'(out2), 32'h11);
    chk("t3_ready_reopen", 32'(ifc.in_ready), 32'd1);
    step();
    drive(1'b0, 3'd0, 8'h00);
    @(negedge clk);
    chk("t3_out2_second", 32'(out2), 32'h22);
    chk("t3_out4_pending", 32'(out4), 32'h14);
    step();
    @(negedge clk);
    chk("t3_out4_third", 32'(out4), 32'h33);
    chk("t3_busy_done", 32'(busy), 32'd0);

    // 4: reset while FULL discards both buffered writes
    hold = 1'b1;
    drive(1'b1, 3'd2, 8'h44);
    step();
    drive(1'b1, 3'd2, 8'h55);
    step();
    drive(1'b0, 3'd0, 8'h00);
    @(negedge clk);
    chk("t4_full_ready", 32'(ifc.in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_ready_in_reset", 32'(ifc.in_ready), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_out2", 32'(out2), 32'h00);
    chk("t4_in_ready", 32'(ifc.in_ready), 32'd1);
    hold = 1'b0;
    step();
    step();
    step();
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk("t4_never_written", 32'(outs[i]), 32'h00);

    // 5: requests while not ready are ignored
    hold = 1'b1;
    drive(1'b1, 3'd6, 8'h66);
    step();
    drive(1'b1, 3'd7, 8'h77);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd1, 8'hC0 + 8'(k));
      @(negedge clk);
      chk("t5_ready_low", 32'(ifc.in_ready), 32'd0);
      step();
    end
    drive(1'b0, 3'bxxx, 8'hxx);
    hold = 1'b0;
    step();
    step();
    step();
    @(negedge clk);
    chk("t5_out6", 32'(out6), 32'h66);
    chk("t5_out7", 32'(out7), 32'h77);
    chk("t5_out1_untouched", 32'(out1), 32'h00);
    chk("t5_busy", 32'(busy), 32'd0);
    drive(1'b0, 3'd0, 8'h00);

`ifdef DEMUX8X8_DIRTY_EN
    // 6: clear coincident with a commit keeps only the committed flag
    chk("t6_dirty_before", 32'(dirty), 32'hC0);
    step();
    drive(1'b1, 3'd3, 8'h99);
    step();
    drive(1'b0, 3'd0, 8'h00);
    dirty_clr = 1'b1;
    step();
    dirty_clr = 1'b0;
    @(negedge clk);
    chk("t6_dirty_clr_commit", 32'(dirty), 32'h08);
    chk("t6_out3", 32'(out3), 32'h99);
    dirty_clr = 1'b1;
    step();
    dirty_clr = 1'b0;
    @(negedge clk);
    chk("t6_dirty_clr_alone", 32'(dirty), 32'h00);
`endif

    step();
    @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
